// File: rtl/instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq
//
// Small instruction-fetch sequencer. A program is loaded word by word into a
// local memory while the block is IDLE or DONE. A start pulse then runs the
// program from pc 0. One instruction is issued per cycle with zero-cycle
// fetch latency. The run ends in DONE when one of these happens:
//   - execution falls off the end of the program,
//   - a branch or fall-through targets a pc outside the loaded program
//     (err_range is set),
//   - the run-length watchdog expires (err_timeout is set).
//
// Optional feature: define IFS_BRANCH_CNT_EN to add output br_cnt, a
// saturating per-run count of taken branches.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   ld_we         program-load write strobe (ignored in RUN)
//   ld_addr       program-load word index
//   ld_data       program-load instruction word
//   start         single-cycle pulse that begins a run at pc 0
//   branch_taken  core's branch decision for the current instr
//   instr         instruction presented to the core (NOP outside RUN)
//   pc            byte address of instr
//   busy          high while in RUN
//   done          high while in DONE
//   err_range     sticky: the next pc fell outside the loaded program
//   err_timeout   sticky: the watchdog expired
//   cycle_cnt     instructions issued in the current or last run
//   br_cnt        taken branches in the current or last run
//                 (present only with IFS_BRANCH_CNT_EN)
// ---------------------------------------------------------------------------
module instr_fetch_seq #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int MAX_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              start,
    input  logic              branch_taken,
    output logic [31:0]       instr,
    output logic [31:0]       pc,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic              err_timeout,
    output logic [15:0]       cycle_cnt
`ifdef IFS_BRANCH_CNT_EN
    ,
    output logic [15:0]       br_cnt
`endif
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_BRANCH = 7'b110_0011;
    localparam logic [15:0] TO_LIMIT  = 16'(MAX_CYCLES - 1);

    // The memory is indexed directly by pc bits, so every index must be a
    // real word.
    if (DEPTH != 2**ADDR_W) begin : g_bad_depth
        $error("instr_fetch_seq: DEPTH must equal 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]     mem [DEPTH];
    logic [ADDR_W:0] prog_len, prog_len_nxt;

    logic [31:0] pc_nxt;
    logic [15:0] cycle_cnt_nxt;
    logic        err_range_nxt, err_timeout_nxt;

    logic        ld_accept;
    logic        is_branch, take_branch;
    logic [31:0] imm_b, next_pc;
    logic        fall_off, range_bad, timeout_hit;

    // ---------------- program memory ----------------
    assign ld_accept = ld_we && (state != RUN);

    // NOTE: the program memory has no reset; only prog_len decides which
    // words are valid. This lets the array map onto plain RAM.
    always_ff @(posedge clk) begin
        if (ld_accept && !rst) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // The program length grows to cover the highest loaded index. It is
    // computed from the incoming write, so a start in the same cycle as the
    // very first load is still accepted.
    always_comb begin
        prog_len_nxt = prog_len;
        if (ld_accept && (({1'b0, ld_addr} + 1'b1) > prog_len)) begin
            prog_len_nxt = {1'b0, ld_addr} + 1'b1;
        end
    end

    // ---------------- fetch and next-pc ----------------
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign instr = busy ? mem[pc[ADDR_W+1:2]] : NOP;

    assign is_branch   = (instr[6:0] == OP_BRANCH);
    assign take_branch = is_branch && branch_taken;
    assign imm_b       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
    assign next_pc     = take_branch ? (pc + imm_b) : (pc + 32'd4);

    // Sequential flow that steps exactly one word past the program is a
    // normal end of run. Any other target at or beyond prog_len is an error,
    // including a taken branch that lands on that same word.
    assign fall_off    = !take_branch &&
                         (next_pc[31:2] == {{(30-ADDR_W-1){1'b0}}, prog_len});
    assign range_bad   = (next_pc[1:0] != 2'b00) ||
                         ((next_pc[31:2] >= {{(30-ADDR_W-1){1'b0}}, prog_len}) &&
                          !fall_off);
    assign timeout_hit = (cycle_cnt == TO_LIMIT);

    // ---------------- next-state / datapath ----------------
    // NOTE: every signal written below gets its hold value first, so no
    // path through the case statement leaves a signal unassigned and no
    // latch is inferred.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        cycle_cnt_nxt   = cycle_cnt;
        err_range_nxt   = err_range;
        err_timeout_nxt = err_timeout;

        unique case (state)
            IDLE, DONE: begin
                if (start && (prog_len_nxt != '0)) begin
                    state_nxt       = RUN;
                    pc_nxt          = '0;
                    cycle_cnt_nxt   = '0;
                    err_range_nxt   = 1'b0;
                    err_timeout_nxt = 1'b0;
                end
            end
            RUN: begin
                if (cycle_cnt != 16'hFFFF) begin
                    cycle_cnt_nxt = cycle_cnt + 16'd1;
                end
                if (range_bad) begin
                    err_range_nxt = 1'b1;
                end
                if (timeout_hit) begin
                    err_timeout_nxt = 1'b1;
                end
                // On any run-ending condition pc keeps the last issued address.
                if (range_bad || fall_off || timeout_hit) begin
                    state_nxt = DONE;
                end else begin
                    pc_nxt = next_pc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every register
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            prog_len    <= '0;
            cycle_cnt   <= '0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            prog_len    <= prog_len_nxt;
            cycle_cnt   <= cycle_cnt_nxt;
            err_range   <= err_range_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

`ifdef IFS_BRANCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt <= '0;
        end else if ((state != RUN) && start && (prog_len_nxt != '0)) begin
            br_cnt <= '0;
        end else if (busy && take_branch && (br_cnt != 16'hFFFF)) begin
            br_cnt <= br_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_seq
//
// Directed self-checking bench for instr_fetch_seq. It covers:
//   - reset state,
//   - straight-line run and fall-off-the-end,
//   - taken branch, with a load and start in the same cycle,
//   - out-of-range branch error and restart clearing the error,
//   - self-loop watchdog timeout,
//   - reset in the middle of a run.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic        start;
    logic        branch_taken;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        busy;
    logic        done;
    logic        err_range;
    logic        err_timeout;
    logic [15:0] cycle_cnt;
`ifdef IFS_BRANCH_CNT_EN
    logic [15:0] br_cnt;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    instr_fetch_seq #(.DEPTH(16), .ADDR_W(4), .MAX_CYCLES(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_we        (ld_we),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .start        (start),
        .branch_taken (branch_taken),
        .instr        (instr),
        .pc           (pc),
        .busy         (busy),
        .done         (done),
        .err_range    (err_range),
        .err_timeout  (err_timeout),
        .cycle_cnt    (cycle_cnt)
`ifdef IFS_BRANCH_CNT_EN
        ,
        .br_cnt       (br_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check("done_reached", {31'b0, done}, 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        ld_we        = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        start        = 1'b0;
        branch_taken = 1'b0;
        step();
        step();
        rst = 1'b0;

        // ---- reset state ----
        check("rst_busy",   {31'b0, busy},        32'd0);
        check("rst_done",   {31'b0, done},        32'd0);
        check("rst_pc",     pc,                   32'd0);
        check("rst_instr",  instr,                NOP);
        check("rst_cnt",    {16'b0, cycle_cnt},   32'd0);
        check("rst_errs",   {30'b0, err_range, err_timeout}, 32'd0);

        // ---- straight-line program, falls off the end ----
        load(4'd0, 32'h0050_0093);
        load(4'd1, 32'h00A0_0113);
        load(4'd2, 32'h0020_81B3);
        pulse_start();
        check("a_busy",   {31'b0, busy}, 32'd1);
        check("a_pc0",    pc,            32'd0);
        check("a_instr0", instr,         32'h0050_0093);
        step();
        check("a_pc1",    pc,            32'd4);
        check("a_instr1", instr,         32'h00A0_0113);
        start = 1'b1;                    // start during RUN is ignored
        step();
        start = 1'b0;
        check("a_pc2",    pc,            32'd8);
        check("a_instr2", instr,         32'h0020_81B3);
        step();
        check("a_done",   {31'b0, done}, 32'd1);
        check("a_idle_busy", {31'b0, busy}, 32'd0);
        check("a_cnt",    {16'b0, cycle_cnt}, 32'd3);
        check("a_errs",   {30'b0, err_range, err_timeout}, 32'd0);
        check("a_nop",    instr,         NOP);

        // ---- taken beq +8; word 0 loaded in the same cycle as start ----
        load(4'd1, 32'h0020_8463);
        load(4'd2, NOP);
        load(4'd3, NOP);
        branch_taken = 1'b1;
        ld_we   = 1'b1;
        ld_addr = 4'd0;
        ld_data = NOP;
        start   = 1'b1;
        step();
        ld_we = 1'b0;
        start = 1'b0;
        check("b_pc0",    pc,    32'd0);
        check("b_instr0", instr, NOP);
        step();
        check("b_pc1",    pc,    32'd4);
        check("b_instr1", instr, 32'h0020_8463);
        step();
        check("b_pc2",    pc,    32'd12);
        step();
        check("b_done",   {31'b0, done}, 32'd1);
        check("b_cnt",    {16'b0, cycle_cnt}, 32'd3);
        check("b_errs",   {30'b0, err_range, err_timeout}, 32'd0);
`ifdef IFS_BRANCH_CNT_EN
        check("b_br_cnt", {16'b0, br_cnt}, 32'd1);
`endif
        branch_taken = 1'b0;

        // ---- branch out of the 2-word program ----
        do_reset();
        load(4'd0, NOP);
        load(4'd1, 32'h0020_8463);
        branch_taken = 1'b1;
        pulse_start();
        check("c_pc0", pc, 32'd0);
        step();
        check("c_pc1", pc, 32'd4);
        step();
        check("c_err_range", {31'b0, err_range},   32'd1);
        check("c_err_to",    {31'b0, err_timeout}, 32'd0);
        check("c_done",      {31'b0, done},        32'd1);
        check("c_pc_hold",   pc,                   32'd4);
        check("c_cnt",       {16'b0, cycle_cnt},   32'd2);
        // restart clears the sticky flag
        branch_taken = 1'b0;
        pulse_start();
        check("c2_err_clr", {31'b0, err_range}, 32'd0);
        check("c2_busy",    {31'b0, busy},      32'd1);
        wait_done(10);
        check("c2_cnt",     {16'b0, cycle_cnt}, 32'd2);
        check("c2_errs",    {30'b0, err_range, err_timeout}, 32'd0);

        // ---- self-loop beq x0,x0,0 trips the watchdog ----
        do_reset();
        load(4'd0, 32'h0000_0063);
        branch_taken = 1'b1;
        pulse_start();
        wait_done(1100);
        check("d_err_to",    {31'b0, err_timeout}, 32'd1);
        check("d_err_range", {31'b0, err_range},   32'd0);
        check("d_cnt",       {16'b0, cycle_cnt},   32'd1024);
        check("d_pc",        pc,                   32'd0);
        branch_taken = 1'b0;

        // ---- reset during cycle 2 of a run ----
        do_reset();
        load(4'd0, 32'h0050_0093);
        load(4'd1, 32'h00A0_0113);
        load(4'd2, 32'h0020_81B3);
        pulse_start();
        step();
        check("e_pc_run", pc, 32'd4);
        rst   = 1'b1;                    // also overrides start and ld_we
        start = 1'b1;
        ld_we = 1'b1;
        ld_addr = 4'd5;
        step();
        rst   = 1'b0;
        start = 1'b0;
        ld_we = 1'b0;
        check("e_busy",  {31'b0, busy}, 32'd0);
        check("e_pc",    pc,            32'd0);
        check("e_instr", instr,         NOP);
        check("e_cnt",   {16'b0, cycle_cnt}, 32'd0);
        pulse_start();
        check("e_start_ignored", {31'b0, busy}, 32'd0);
        step();
        check("e_still_idle", {30'b0, busy, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
